// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_pkg
//  Purpose  : Shared definitions for the 7-segment scan scheduler and its
//             integration: word width, field layout of the word handed to
//             the shift-register engine, and the scheduler state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package seg_scan_pkg;

    // Word handed to the shift-register engine: {segments, digit one-hot}
    localparam int WORD_WIDTH = 16;
    localparam int SEG_LSB    = 8;
    localparam int SEG_WIDTH  = 8;
    localparam int SEL_LSB    = 0;
    localparam int SEL_WIDTH  = 8;

    typedef struct packed {
        logic [SEG_WIDTH-1:0] seg;   // bits [15:8]
        logic [SEL_WIDTH-1:0] sel;   // bits [7:0]
    } scan_word_t;

    // Scheduler states
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ADVANCE    = 3'd1;
    localparam logic [2:0] ST_SEND_DIGIT = 3'd2;
    localparam logic [2:0] ST_DWELL      = 3'd3;
    localparam logic [2:0] ST_SEND_BLANK = 3'd4;

    // Build a word from its two fields using the published offsets
    function automatic logic [WORD_WIDTH-1:0] pack_word(
        input logic [SEG_WIDTH-1:0] seg,
        input logic [SEL_WIDTH-1:0] sel
    );
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        w[SEG_LSB +: SEG_WIDTH] = seg;
        w[SEL_LSB +: SEL_WIDTH] = sel;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_7seg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_to_7seg
//  Purpose  : Hex nibble to active-high 7-segment pattern.
//             o_seg = {dp, g, f, e, d, c, b, a}; dp is always off.
//  Ports    : i_nibble  4-bit hex value
//             o_seg     8-bit segment pattern
//  Revision : 1.0  initial release
// ============================================================================
module hex_to_7seg (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = 8'h00;
        case (i_nibble)
            4'h0: o_seg = 8'h3F;
            4'h1: o_seg = 8'h06;
            4'h2: o_seg = 8'h5B;
            4'h3: o_seg = 8'h4F;
            4'h4: o_seg = 8'h66;
            4'h5: o_seg = 8'h6D;
            4'h6: o_seg = 8'h7D;
            4'h7: o_seg = 8'h07;
            4'h8: o_seg = 8'h7F;
            4'h9: o_seg = 8'h6F;
            4'hA: o_seg = 8'h77;
            4'hB: o_seg = 8'h7C;
            4'hC: o_seg = 8'h39;
            4'hD: o_seg = 8'h5E;
            4'hE: o_seg = 8'h79;
            4'hF: o_seg = 8'h71;
            default: o_seg = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_scheduler
//  Purpose  : Multiplexed 7-segment display scheduler. Walks the enabled
//             digits, offers one {segments, one-hot} word per digit to a
//             shift-register engine over a valid/ready handshake, keeps each
//             digit lit for DWELL_CYCLES, optionally follows it with an
//             all-dark anti-ghost word, and shuts down cleanly (dark display)
//             when scanning is disabled.
//  Ports    : i_clk, i_reset      clock, synchronous active-high reset
//             i_enable            scan enable
//             i_digits            hex nibble per digit, digit k at [4k+3:4k]
//             i_digit_mask        per-digit display enable
//             i_word_ready        engine can accept a word
//             o_word/o_word_valid word offered to the engine
//             o_digit_sel         digit index being sent or dwelling
//             o_frame_done        pulse when the index wraps to 0
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_scheduler
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int DWELL_CYCLES = 4096,
    parameter int BLANK_EN     = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]   i_digit_mask,
    input  logic                    i_word_ready,
    output logic [WORD_WIDTH-1:0]   o_word,
    output logic                    o_word_valid,
    output logic [2:0]              o_digit_sel,
    output logic                    o_frame_done
);

    localparam int              CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]       C_LAST_IDX   = 3'(NUM_DIGITS - 1);

    logic [2:0]       r_state;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_nibble;

    logic [2:0]       w_state_next;
    logic [2:0]       w_idx_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       w_nibble_next;
    logic             w_step;        // advance the digit index this cycle
    logic             w_xfer;
    logic [2:0]       w_idx_inc;
    logic [7:0]       w_mask8;
    logic [31:0]      w_digits32;
    logic [7:0]       w_seg;
    logic [7:0]       w_onehot;
    scan_word_t       w_word;

    // Zero-extend to the 8-digit maximum so a 3-bit index selects cleanly
    assign w_mask8    = 8'(i_digit_mask);
    assign w_digits32 = 32'(i_digits);

    assign w_idx_inc  = (r_idx == C_LAST_IDX) ? 3'd0 : r_idx + 3'd1;
    assign w_xfer     = o_word_valid & i_word_ready;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_nibble_next = r_nibble;
        w_step        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_state_next = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (!i_enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_mask8[r_idx]) begin
                    // Latch now so later input changes cannot alter the word in flight
                    w_nibble_next = w_digits32[{r_idx, 2'b00} +: 4];
                    w_state_next  = ST_SEND_DIGIT;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_SEND_DIGIT: begin
                // The pending word always completes; a disable is honoured in DWELL
                if (w_xfer) begin
                    w_cnt_next   = C_DWELL_LOAD;
                    w_state_next = ST_DWELL;
                end
            end
            ST_DWELL: begin
                if (!i_enable) begin
                    // Shutdown always goes dark, even without anti-ghost blanking
                    w_state_next = ST_SEND_BLANK;
                end else if (r_cnt == '0) begin
                    if (BLANK_EN != 0) begin
                        w_state_next = ST_SEND_BLANK;
                    end else begin
                        w_step       = 1'b1;
                        w_state_next = ST_ADVANCE;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_SEND_BLANK: begin
                // The index moves on in both cases so a restart resumes at the next digit
                if (w_xfer) begin
                    w_step       = 1'b1;
                    w_state_next = i_enable ? ST_ADVANCE : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_idx_next = w_step ? w_idx_inc : r_idx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= 3'd0;
            r_cnt    <= '0;
            r_nibble <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_cnt    <= w_cnt_next;
            r_nibble <= w_nibble_next;
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .i_nibble (r_nibble),
        .o_seg    (w_seg)
    );

    assign w_onehot = 8'b0000_0001 << r_idx;

    always_comb begin
        w_word = '0;
        if (r_state == ST_SEND_DIGIT) begin
            w_word.seg = w_seg;
            w_word.sel = w_onehot;
        end
    end

    // Outputs derive from registered state only, so they hold steady under backpressure
    assign o_word       = pack_word(w_word.seg, w_word.sel);
    assign o_word_valid = (r_state == ST_SEND_DIGIT) || (r_state == ST_SEND_BLANK);
    assign o_digit_sel  = r_idx;
    // Wrap happens only from the last index, so back-to-back pulses are impossible
    assign o_frame_done = w_step && (r_idx == C_LAST_IDX);

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_scheduler
//  Purpose  : Self-checking bench for seg_scan_scheduler (3 digits, dwell 4,
//             blanking on). Table-driven scan vectors plus directed
//             sequences for backpressure, empty mask, shutdown and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [11:0] digits;
    logic [2:0]  mask;
    logic        ready;
    logic [15:0] word;
    logic        valid;
    logic [2:0]  sel;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int frames = 0;

    typedef struct {
        logic [15:0] word;
        int          cyc;
        int          frames;
    } xfer_t;
    xfer_t q[$];

    typedef struct {
        logic [11:0]      digits;
        logic [2:0]       mask;
        logic [5:0][15:0] words;
        int               gap12;   // cycles from first blank to second digit
    } vec_t;
    vec_t vecs[6];

    seg_scan_scheduler #(
        .NUM_DIGITS   (3),
        .DWELL_CYCLES (4),
        .BLANK_EN     (1)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_enable     (enable),
        .i_digits     (digits),
        .i_digit_mask (mask),
        .i_word_ready (ready),
        .o_word       (word),
        .o_word_valid (valid),
        .o_digit_sel  (sel),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer monitor: logs every accepted word with its cycle and frame count
    always @(negedge clk) begin
        if (!rst) begin
            xfer_t t;
            if (frame_done) frames = frames + 1;
            if (valid && ready) begin
                t.word   = word;
                t.cyc    = cyc;
                t.frames = frames;
                q.push_back(t);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [11:0] d, input logic [2:0] m,
                            input logic en, input logic rdy);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        enable = 1'b0;
        ready  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        digits = d;
        mask   = m;
        enable = en;
        ready  = rdy;
        rst    = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, got %0d words expected %0d", name, q.size(), n);
        end
    endtask

    task automatic set_vec(input int i, input logic [11:0] d, input logic [2:0] m,
                           input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5,
                           input int g);
        vecs[i].digits   = d;
        vecs[i].mask     = m;
        vecs[i].words[0] = w0;
        vecs[i].words[1] = w1;
        vecs[i].words[2] = w2;
        vecs[i].words[3] = w3;
        vecs[i].words[4] = w4;
        vecs[i].words[5] = w5;
        vecs[i].gap12    = g;
    endtask

    initial begin
        int b;
        int fb;
        int nvalid;
        int pulses[$];

        rst = 1'b1; enable = 1'b0; digits = '0; mask = '0; ready = 1'b0;

        // seg codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71
        set_vec(0, 12'h321, 3'b111, 16'h0601, 16'h0000, 16'h5B02, 16'h0000, 16'h4F04, 16'h0000, 2);
        set_vec(1, 12'hA5F, 3'b111, 16'h7101, 16'h0000, 16'h6D02, 16'h0000, 16'h7704, 16'h0000, 2);
        set_vec(2, 12'h8C0, 3'b101, 16'h3F01, 16'h0000, 16'h7F04, 16'h0000, 16'h3F01, 16'h0000, 3);
        set_vec(3, 12'h9E4, 3'b111, 16'h6601, 16'h0000, 16'h7902, 16'h0000, 16'h6F04, 16'h0000, 2);
        set_vec(4, 12'hB7D, 3'b111, 16'h5E01, 16'h0000, 16'h0702, 16'h0000, 16'h7C04, 16'h0000, 2);
        set_vec(5, 12'h462, 3'b110, 16'h7D02, 16'h0000, 16'h6604, 16'h0000, 16'h7D02, 16'h0000, 2);

        // ---------------- reset state ----------------
        do_reset(12'h321, 3'b111, 1'b0, 1'b0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_word", 32'(word), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);

        // ---------------- table-driven scan vectors ----------------
        for (int v = 0; v < 6; v++) begin
            do_reset(vecs[v].digits, vecs[v].mask, 1'b1, 1'b1);
            b  = q.size();
            fb = frames;
            wait_words(b + 6, 200, $sformatf("vec%0d_words", v));
            if (q.size() >= b + 6) begin
                for (int k = 0; k < 6; k++) begin
                    chk($sformatf("vec%0d_word%0d", v, k), 32'(q[b+k].word), 32'(vecs[v].words[k]));
                end
                chk($sformatf("vec%0d_dwell_gap", v), 32'(q[b+1].cyc - q[b].cyc), 32'd5);
                chk($sformatf("vec%0d_advance_gap", v), 32'(q[b+2].cyc - q[b+1].cyc), 32'(vecs[v].gap12));
                chk($sformatf("vec%0d_frames", v), 32'(q[b+5].frames - fb), 32'd1);
            end
        end

        // ---------------- backpressure during SEND_DIGIT ----------------
        do_reset(12'h321, 3'b111, 1'b1, 1'b0);
        b = q.size();
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!valid && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        chk("bp_first_offer", {15'd0, valid, word}, {15'd0, 1'b1, 16'h0601});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) digits = 12'hFFF;
            chk($sformatf("bp_hold%0d", i), {15'd0, valid, word}, {15'd0, 1'b1, 16'h0601});
        end
        @(posedge clk);
        #1 ready = 1'b1;
        wait_words(b + 1, 20, "bp_xfer");
        if (q.size() >= b + 1) chk("bp_latched_word", 32'(q[b].word), 32'h0601);

        // ---------------- all-zero mask ----------------
        do_reset(12'h321, 3'b000, 1'b1, 1'b1);
        nvalid = 0;
        pulses.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid) nvalid++;
            if (frame_done) pulses.push_back(cyc);
        end
        chk("zmask_no_valid", 32'(nvalid), 32'd0);
        chk("zmask_pulse_count_ok", 32'(pulses.size() >= 9), 32'd1);
        for (int i = 1; i < pulses.size(); i++) begin
            chk($sformatf("zmask_period%0d", i), 32'(pulses[i] - pulses[i-1]), 32'd3);
        end

        // ---------------- enable dropped in DWELL ----------------
        do_reset(12'h321, 3'b111, 1'b1, 1'b1);
        b = q.size();
        wait_words(b + 1, 40, "shut_first");
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        chk("shut_dwell_quiet", 32'(valid), 32'd0);
        @(negedge clk);
        chk("shut_blank_offer", {15'd0, valid, word}, {15'd0, 1'b1, 16'h0000});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("shut_idle%0d", i), {28'd0, valid, sel}, {28'd0, 1'b0, 3'd1});
        end
        chk("shut_word_count", 32'(q.size() - b), 32'd2);
        b = q.size();
        @(posedge clk);
        #1 enable = 1'b1;
        wait_words(b + 1, 40, "resume_xfer");
        if (q.size() >= b + 1) chk("resume_next_digit", 32'(q[b].word), 32'h5B02);

        // ---------------- reset during SEND_BLANK with ready low ----------------
        do_reset(12'h321, 3'b111, 1'b1, 1'b1);
        b = q.size();
        wait_words(b + 1, 40, "rst_first");
        #1 ready = 1'b0;
        begin
            int k;
            k = 0;
            @(negedge clk);
            while (!valid && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        chk("rst_blank_pending", {15'd0, valid, word}, {15'd0, 1'b1, 16'h0000});
        b = q.size();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 32'(valid), 32'd0);
        chk("rst_mid_word", 32'(word), 32'd0);
        chk("rst_mid_sel", 32'(sel), 32'd0);
        chk("rst_mid_frame_done", 32'(frame_done), 32'd0);
        chk("rst_no_transfer", 32'(q.size() - b), 32'd0);
        rst = 1'b0;
        wait_words(b + 1, 40, "rst_restart");
        if (q.size() >= b + 1) chk("rst_restart_digit0", 32'(q[b].word), 32'h0601);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_scheduler.md
SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 3, giving the number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter DWELL_CYCLES, default 4096, giving the clock cycles each digit stays lit after its word is accepted (legal >=1).
REQ-003 The block SHALL have parameter BLANK_EN, default 1; 1 inserts an all-zero anti-ghost word after each digit.
REQ-004 i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_enable  input  1  1 = scan digits; 0 = stop scanning after a clean shutdown.
REQ-007 i_digits  input  4*NUM_DIGITS  hex nibble per digit; digit k occupies [4k+3:4k].
REQ-008 i_digit_mask  input  NUM_DIGITS  1 = digit k displayed; 0 = digit k skipped.
REQ-009 i_word_ready  input  1  shift-register engine can accept a word this cycle.
REQ-010 o_word  output  16  {segments[7:0], digit one-hot[7:0]} for the shift-register engine.
REQ-011 o_word_valid  output  1  o_word is offered for transfer.
REQ-012 o_digit_sel  output  3  index of the digit currently being sent or dwelling.
REQ-013 o_frame_done  output  1  one-cycle pulse when the digit index wraps from the last digit to 0.

Function
REQ-014 A word SHALL transfer on any cycle with o_word_valid=1 and i_word_ready=1; valid and word SHALL stay stable until then.
REQ-015 The FSM SHALL have states IDLE, ADVANCE, SEND_DIGIT, DWELL, SEND_BLANK.
REQ-016 IDLE SHALL move to ADVANCE when i_enable=1 and SHALL otherwise hold with o_word_valid=0.
REQ-017 ADVANCE SHALL take one cycle per digit index; if mask[idx]=1 it SHALL latch nibble idx and go to SEND_DIGIT, else increment idx and stay in ADVANCE.
REQ-018 Index increment SHALL wrap from NUM_DIGITS-1 to 0 and pulse o_frame_done in that cycle; an all-zero mask SHALL therefore cycle ADVANCE with a pulse every NUM_DIGITS cycles and no words.
REQ-019 SEND_DIGIT SHALL drive o_word = {hex_to_7seg(latched nibble), one-hot(idx)} with valid=1; on transfer it SHALL load the dwell counter with DWELL_CYCLES-1 and enter DWELL.
REQ-020 Changes to i_digits or i_digit_mask after the latch SHALL NOT alter the word in flight.
REQ-021 DWELL SHALL drive valid=0 and decrement the counter; at counter 0 it SHALL go to SEND_BLANK if BLANK_EN=1, else increment idx and go to ADVANCE.
REQ-022 SEND_BLANK SHALL drive o_word=16'h0000 with valid=1; on transfer it SHALL increment idx and go to ADVANCE, or go to IDLE if i_enable=0.
REQ-023 With i_enable=0 in DWELL, the block SHALL immediately enter SEND_BLANK (regardless of BLANK_EN), then IDLE, so the display is left dark.
REQ-024 With i_enable=0 in SEND_DIGIT, the pending word SHALL still complete its handshake, then the block SHALL take the REQ-023 path.
REQ-025 With i_enable=0 in ADVANCE, the block SHALL return to IDLE next cycle without sending a word.
REQ-026 From IDLE, scanning SHALL resume at the held idx.
REQ-027 o_frame_done SHALL never be high for two consecutive cycles when NUM_DIGITS>1.

Reset
REQ-028 When i_reset=1 at a clock edge, the next state SHALL be IDLE, idx=0, dwell counter=0, o_word=0, o_word_valid=0, o_frame_done=0, o_digit_sel=0.
REQ-029 Reset SHALL override any in-progress handshake; a word offered in the reset cycle is considered not transferred.

Structure
REQ-030 State encoding, WORD_WIDTH=16 and the {segments, one-hot} field offsets SHALL live in a shared package, seg_scan_pkg, also used by the top-level integration.
REQ-031 Segment decoding SHALL reuse the existing hex_to_7seg as the single sub-module instance; one-hot generation SHALL be inline.

Verification
REQ-032 DWELL_CYCLES=4, digits=12'h321, mask=3'b111, ready=1: transfers {seg(1),8'h01}, 0, {seg(2),8'h02}, 0, {seg(3),8'h04}, 0; 4 idle cycles between each digit and its blank; frame_done pulses once per frame.
REQ-033 Ready held low 10 cycles during SEND_DIGIT: valid=1 with o_word stable all 10 cycles; i_digits changed to 12'hFFF meanwhile; transferred word still shows the latched nibble.
REQ-034 mask=3'b101: only digits 0 and 2 are sent; digit 1 costs exactly one ADVANCE cycle; mask=3'b000 gives no valid and frame_done every 3 cycles.
REQ-035 i_enable dropped at DWELL cycle 2: blank word sent next, then IDLE with valid=0; re-enable resumes at the next digit index.
REQ-036 i_reset asserted during SEND_BLANK with ready=0: next cycle all outputs are 0 and the state is IDLE; scanning restarts at digit 0.
